// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared definitions for the UART frame parser.
//   SOF0/SOF1     - the two start-of-frame sync bytes
//   frame_state_e - parser FSM states
//   ptr_width()   - buffer pointer width for a given payload capacity
package uart_frame_pkg;

  localparam logic [7:0] SOF0 = 8'h55;
  localparam logic [7:0] SOF1 = 8'hAA;

  typedef enum logic [2:0] {
    StHunt0,
    StHunt1,
    StCmd,
    StLen,
    StPayload,
    StChk,
    StDrain
  } frame_state_e;

  // Never returns 0, so a one-entry buffer still gets a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: DEPTH x 8 simple dual-port register buffer holding one frame payload.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data at raddr
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: decodes 0x55 0xAA CMD LEN payload CHK frames from the uart_rx byte
// stream and releases the payload of good frames over a valid/ready byte stream.
// CHK is the 8-bit sum of CMD, LEN and all payload bytes.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   rx_data, rx_en        - received byte and its one-cycle strobe
//   out_data, out_valid,
//   out_ready, out_last   - payload stream of the last good frame
//   frame_cmd, frame_len  - CMD/LEN of the last good frame
//   frame_done            - pulse: good frame accepted
//   err_chk, err_len,
//   err_ovr, err_timeout  - pulses: checksum bad, LEN too large, byte dropped in drain, timeout
// Build option: define UART_FRAME_TIMEOUT_EN to enable the inter-byte timeout; otherwise
// err_timeout is tied to 0 and a partial frame waits indefinitely.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 4340
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] frame_cmd,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_ovr,
  output logic       err_timeout
);

  localparam int unsigned PW       = ptr_width(MAX_LEN);
  localparam logic [7:0]  MaxLen8  = 8'(MAX_LEN);

  frame_state_e    state_q;
  logic [7:0]      cmd_q, len_q, sum_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]      frame_cmd_q, frame_len_q;
  logic            out_valid_q, frame_done_q;
  logic            err_chk_q, err_len_q, err_ovr_q;
  logic            tmo_hit;
  logic            wr_last, rd_last, buf_we;
  logic [7:0]      rd_data;

  // Only meaningful in PAYLOAD/DRAIN, where len_q is non-zero.
  assign wr_last = (8'(wr_ptr_q) == len_q - 8'd1);
  assign rd_last = (8'(rd_ptr_q) == len_q - 8'd1);
  assign buf_we  = (state_q == StPayload) && rx_en;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata (rx_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StHunt0;
      cmd_q        <= '0;
      len_q        <= '0;
      sum_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_cmd_q  <= '0;
      frame_len_q  <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_chk_q    <= 1'b0;
      err_len_q    <= 1'b0;
      err_ovr_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      err_chk_q    <= 1'b0;
      err_len_q    <= 1'b0;
      err_ovr_q    <= 1'b0;
      if (tmo_hit) begin
        state_q <= StHunt0;
      end else begin
        unique case (state_q)
          StHunt0: begin
            if (rx_en && rx_data == SOF0) state_q <= StHunt1;
          end
          StHunt1: begin
            if (rx_en) begin
              if (rx_data == SOF1)      state_q <= StCmd;
              else if (rx_data != SOF0) state_q <= StHunt0;
            end
          end
          StCmd: begin
            if (rx_en) begin
              cmd_q   <= rx_data;
              sum_q   <= rx_data;
              state_q <= StLen;
            end
          end
          StLen: begin
            if (rx_en) begin
              len_q    <= rx_data;
              sum_q    <= sum_q + rx_data;
              wr_ptr_q <= '0;
              if (rx_data > MaxLen8) begin
                err_len_q <= 1'b1;
                state_q   <= StHunt0;
              end else if (rx_data == 8'd0) begin
                state_q <= StChk;
              end else begin
                state_q <= StPayload;
              end
            end
          end
          StPayload: begin
            if (rx_en) begin
              sum_q    <= sum_q + rx_data;
              wr_ptr_q <= wr_ptr_q + PW'(1);
              if (wr_last) state_q <= StChk;
            end
          end
          StChk: begin
            if (rx_en) begin
              if (rx_data == sum_q) begin
                frame_done_q <= 1'b1;
                frame_cmd_q  <= cmd_q;
                frame_len_q  <= len_q;
                if (len_q != 8'd0) begin
                  out_valid_q <= 1'b1;
                  rd_ptr_q    <= '0;
                  state_q     <= StDrain;
                end else begin
                  state_q <= StHunt0;
                end
              end else begin
                err_chk_q <= 1'b1;
                state_q   <= StHunt0;
              end
            end
          end
          StDrain: begin
            // Incoming bytes are dropped; the buffer is still being read out.
            if (rx_en) err_ovr_q <= 1'b1;
            if (out_valid_q && out_ready) begin
              if (rd_last) begin
                out_valid_q <= 1'b0;
                state_q     <= StHunt0;
              end else begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
              end
            end
          end
          default: state_q <= StHunt0;
        endcase
      end
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] tmo_cnt_q;
  logic          err_timeout_q;
  logic          in_frame;

  assign in_frame = (state_q == StCmd) || (state_q == StLen) ||
                    (state_q == StPayload) || (state_q == StChk);
  // A byte on the terminal cycle takes priority over the timeout.
  assign tmo_hit  = in_frame && !rx_en && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= tmo_hit;
      if (rx_en || !in_frame || tmo_hit) tmo_cnt_q <= '0;
      else                               tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign tmo_hit            = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  // Forced to 0 outside DRAIN so the output never shows stale or unwritten buffer contents.
  assign out_data   = out_valid_q ? rd_data : 8'h00;
  assign out_valid  = out_valid_q;
  assign out_last   = out_valid_q && rd_last;
  assign frame_cmd  = frame_cmd_q;
  assign frame_len  = frame_len_q;
  assign frame_done = frame_done_q;
  assign err_chk    = err_chk_q;
  assign err_len    = err_len_q;
  assign err_ovr    = err_ovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: expected payload bytes and frame headers are
// queued as frames are driven and popped when the DUT presents them.
module tb_uart_frame_parser;

  localparam int unsigned MaxLen = 16;
  localparam int unsigned TmoCyc = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] frame_cmd, frame_len;
  logic       frame_done, err_chk, err_len, err_ovr, err_timeout;

  uart_frame_parser #(
    .MAX_LEN     (MaxLen),
    .TIMEOUT_CYC (TmoCyc)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_en       (rx_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_cmd   (frame_cmd),
    .frame_len   (frame_len),
    .frame_done  (frame_done),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_ovr     (err_ovr),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0, n_chk = 0, n_len = 0, n_ovr = 0, n_tmo = 0;
  int pulse_cnt;

  logic [8:0]  exp_q[$];    // {last, data}
  logic [15:0] frame_q[$];  // {cmd, len}
  logic [7:0]  pl [MaxLen];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_out_valid", 32'(out_valid), 32'd0);
        else check_eq("out_last_data", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
      end
      if (frame_done) begin
        n_done++;
        if (frame_q.size() == 0) begin
          check_eq("unexpected_frame_done", 32'(frame_done), 32'd0);
        end else begin
          logic [15:0] f;
          f = frame_q.pop_front();
          check_eq("frame_cmd_len", 32'({frame_cmd, frame_len}), 32'(f));
          check_eq("valid_with_done", 32'(out_valid), 32'(f[7:0] != 8'd0));
        end
      end
      n_chk += int'(err_chk);
      n_len += int'(err_len);
      n_ovr += int'(err_ovr);
      n_tmo += int'(err_timeout);
      pulse_cnt = int'(frame_done) + int'(err_chk) + int'(err_len) + int'(err_ovr) +
                  int'(err_timeout);
      if (pulse_cnt > 1) check_eq("pulse_exclusive", 32'(pulse_cnt), 32'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_en   = 1'b1;
    @(posedge clk);
    #1;
    rx_en   = 1'b0;
  endtask

  // Sends a full frame from pl[]; LEN > MaxLen sends only the header.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input bit bad);
    logic [7:0] sum;
    sum = cmd + len;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(cmd);
    send_byte(len);
    if (len > 8'(MaxLen)) return;
    for (int i = 0; i < int'(len); i++) begin
      send_byte(pl[i]);
      sum = sum + pl[i];
      if (!bad) exp_q.push_back({(i == int'(len) - 1), pl[i]});
    end
    if (!bad) frame_q.push_back({cmd, len});
    send_byte(bad ? (sum ^ 8'h01) : sum);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || frame_q.size() != 0 || out_valid); i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check_eq(tag, 32'(exp_q.size() + frame_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    rx_en     = 1'b0;
    rx_data   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             32'({out_data, out_valid, out_last, frame_cmd, frame_len, frame_done,
                  err_chk, err_len, err_ovr, err_timeout}), 32'd0);
    rst = 1'b0;

    // Good two-byte frame.
    pl[0] = 8'hA1;
    pl[1] = 8'hB2;
    send_frame(8'h10, 8'd2, 1'b0);
    wait_drain("t1_drain");
    check_eq("t1_done_cnt", 32'(n_done), 32'd1);

    // Bad checksum, header registers held, then a good frame.
    send_frame(8'h33, 8'd2, 1'b1);
    wait_drain("t2_bad_drain");
    check_eq("t2_err_chk_cnt", 32'(n_chk), 32'd1);
    check_eq("t2_hdr_held", 32'({frame_cmd, frame_len}), 32'h1002);
    send_frame(8'h10, 8'd2, 1'b0);
    wait_drain("t2_good_drain");
    check_eq("t2_done_cnt", 32'(n_done), 32'd2);

    // Zero-length frame behind junk and a repeated sync byte.
    send_byte(8'h00);
    send_byte(8'h55);
    send_frame(8'h20, 8'd0, 1'b0);
    wait_drain("t3_drain");
    check_eq("t3_done_cnt", 32'(n_done), 32'd3);
    check_eq("t3_frame_len", 32'(frame_len), 32'd0);

    // Oversized LEN, then a full MaxLen frame.
    send_frame(8'h01, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    check_eq("t4_err_len_cnt", 32'(n_len), 32'd1);
    for (int i = 0; i < int'(MaxLen); i++) pl[i] = 8'(i * 7 + 3);
    send_frame(8'h01, 8'(MaxLen), 1'b0);
    wait_drain("t4_drain");
    check_eq("t4_done_cnt", 32'(n_done), 32'd4);

    // Back-pressure with an overrun byte during drain.
    pl[0] = 8'hA1;
    pl[1] = 8'hB2;
    out_ready = 1'b0;
    send_frame(8'h10, 8'd2, 1'b0);
    repeat (5) @(posedge clk);
    send_byte(8'h77);
    repeat (40) @(posedge clk);
    #1;
    check_eq("t5_hold_valid", 32'(out_valid), 32'd1);
    check_eq("t5_hold_data", 32'(out_data), 32'hA1);
    check_eq("t5_hold_last", 32'(out_last), 32'd0);
    check_eq("t5_err_ovr_cnt", 32'(n_ovr), 32'd1);
    out_ready = 1'b1;
    wait_drain("t5_drain");
    check_eq("t5_done_cnt", 32'(n_done), 32'd5);

    // Inter-byte idle inside a frame.
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h10);
`ifdef UART_FRAME_TIMEOUT_EN
    repeat (TmoCyc - 2) @(posedge clk);
    #1;
    check_eq("t6_no_early_timeout", 32'(n_tmo), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t6_timeout_cnt", 32'(n_tmo), 32'd1);
`else
    repeat (2 * TmoCyc) @(posedge clk);
    #1;
    check_eq("t6_no_timeout", 32'(n_tmo), 32'd0);
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b1, 8'hB2});
    frame_q.push_back(16'h1002);
    send_byte(8'h02);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'h65);
    wait_drain("t6_resume_drain");
    check_eq("t6_resume_done_cnt", 32'(n_done), 32'd6);
`endif
    send_frame(8'h10, 8'd2, 1'b0);
    wait_drain("t6_next_drain");
`ifdef UART_FRAME_TIMEOUT_EN
    check_eq("t6_done_cnt", 32'(n_done), 32'd6);
`else
    check_eq("t6_done_cnt", 32'(n_done), 32'd7);
`endif
    check_eq("total_err_chk", 32'(n_chk), 32'd1);
    check_eq("total_err_len", 32'(n_len), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
